// File: rtl/alu_ctrl_queue.sv
// rtl/alu_ctrl_queue.sv - opcode FIFO feeding a registered ALU control-word decoder
// Optional illegal-opcode checking is enabled by defining ALU_CTRL_ILLEGAL_CHK_EN.
module alu_ctrl_queue #(
    parameter  int FLAG_W = 3,
    parameter  int DEPTH  = 4,
    localparam int OP_W   = FLAG_W + 5,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   ALUop,
    output logic              ctl_valid,
    input  logic              ctl_ready,
    output logic              isArith,
    output logic              isTwoC,
    output logic              LeftOrRight,
    output logic [1:0]        Operation,
    output logic [FLAG_W-1:0] SetFlag,
    output logic [CNT_W-1:0]  count,
    output logic              illegal,
    output logic              sticky_err
);

    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (FLAG_W < 1 || FLAG_W > 8) begin : g_bad_flag_w
            $error("FLAG_W out of range 1..8");
        end
        if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic [OP_W-1:0]   mem_q [DEPTH];
    logic [OP_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ctl_valid_q, ctl_valid_d;
    logic              is_arith_q, is_arith_d;
    logic              is_two_c_q, is_two_c_d;
    logic              left_or_right_q, left_or_right_d;
    logic [1:0]        operation_q, operation_d;
    logic [FLAG_W-1:0] set_flag_q, set_flag_d;

    logic              push;
    logic              load;
    logic              consume;
    logic              fifo_empty;
    logic [OP_W-1:0]   head;

    // op_ready comes only from the registered count so it never depends on ctl_ready.
    assign op_ready   = (count_q < CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        push    = op_valid && op_ready;
        consume = ctl_valid_q && ctl_ready;
        load    = !fifo_empty && (!ctl_valid_q || ctl_ready);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = ALUop;
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Decoded fields hold their last value when the output empties.
        ctl_valid_d     = ctl_valid_q;
        is_arith_d      = is_arith_q;
        is_two_c_d      = is_two_c_q;
        left_or_right_d = left_or_right_q;
        operation_d     = operation_q;
        set_flag_d      = set_flag_q;
        if (load) begin
            ctl_valid_d     = 1'b1;
            is_arith_d      = head[OP_W-1];
            is_two_c_d      = head[OP_W-2];
            left_or_right_d = head[OP_W-3];
            operation_d     = head[OP_W-4:OP_W-5];
            set_flag_d      = head[FLAG_W-1:0];
        end else if (consume) begin
            ctl_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            ctl_valid_q     <= 1'b0;
            is_arith_q      <= 1'b0;
            is_two_c_q      <= 1'b0;
            left_or_right_q <= 1'b0;
            operation_q     <= '0;
            set_flag_q      <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            ctl_valid_q     <= ctl_valid_d;
            is_arith_q      <= is_arith_d;
            is_two_c_q      <= is_two_c_d;
            left_or_right_q <= left_or_right_d;
            operation_q     <= operation_d;
            set_flag_q      <= set_flag_d;
        end
    end

    assign ctl_valid   = ctl_valid_q;
    assign isArith     = is_arith_q;
    assign isTwoC      = is_two_c_q;
    assign LeftOrRight = left_or_right_q;
    assign Operation   = operation_q;
    assign SetFlag     = set_flag_q;
    assign count       = count_q;

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
    logic illegal_q, illegal_d;
    logic sticky_q, sticky_d;
    logic head_illegal;

    // Two's-complement needs arithmetic mode; a shift must use Operation 2'b11.
    always_comb begin
        head_illegal = (head[OP_W-2] && !head[OP_W-1]) ||
                       (head[OP_W-3] && (head[OP_W-4:OP_W-5] != 2'b11));
        illegal_d    = illegal_q;
        if (load) begin
            illegal_d = head_illegal;
        end else if (consume) begin
            illegal_d = 1'b0;
        end
        sticky_d = sticky_q || (load && head_illegal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
            sticky_q  <= sticky_d;
        end
    end

    assign illegal    = illegal_q;
    assign sticky_err = sticky_q;
`else
    assign illegal    = 1'b0;
    assign sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_queue.sv
// tb/tb_alu_ctrl_queue.sv - self-checking bench for alu_ctrl_queue (FLAG_W=3, DEPTH=4)
module tb_alu_ctrl_queue;

    localparam int FLAG_W = 3;
    localparam int DEPTH  = 4;
    localparam int OP_W   = FLAG_W + 5;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   ALUop;
    logic              ctl_valid;
    logic              ctl_ready;
    logic              isArith;
    logic              isTwoC;
    logic              LeftOrRight;
    logic [1:0]        Operation;
    logic [FLAG_W-1:0] SetFlag;
    logic [CNT_W-1:0]  count;
    logic              illegal;
    logic              sticky_err;

    alu_ctrl_queue #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .ALUop(ALUop),
        .ctl_valid(ctl_valid), .ctl_ready(ctl_ready), .isArith(isArith), .isTwoC(isTwoC),
        .LeftOrRight(LeftOrRight), .Operation(Operation), .SetFlag(SetFlag), .count(count),
        .illegal(illegal), .sticky_err(sticky_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef ALU_CTRL_ILLEGAL_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // Reference model: queued words, output register, illegal flags.
    logic [OP_W-1:0] m_fq[$];
    logic            m_ov;
    logic [OP_W-1:0] m_word;
    logic            m_ill;
    logic            m_sticky;
    logic [OP_W-1:0] got[$];

    typedef struct {
        logic [OP_W-1:0]   word;
        logic              arith;
        logic              twoc;
        logic              lr;
        logic [1:0]        op;
        logic [FLAG_W-1:0] flag;
    } vec_t;

    vec_t vecs[5];

    function automatic logic is_ill(input logic [OP_W-1:0] w);
        return (w[OP_W-2] && !w[OP_W-1]) || (w[OP_W-3] && (w[OP_W-4:OP_W-5] != 2'b11));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OP_W-1:0] dut_word();
        return {isArith, isTwoC, LeftOrRight, Operation, SetFlag};
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, advance model.
    task automatic cyc(input logic vld, input logic [OP_W-1:0] w, input logic rdy, input logic r);
        logic pop;
        logic psh;
        op_valid  = vld;
        ALUop     = w;
        ctl_ready = rdy;
        rst       = r;
        #1;
        check("op_ready", op_ready, (m_fq.size() < DEPTH));
        check("count", count, m_fq.size());
        check("ctl_valid", ctl_valid, m_ov);
        if (m_ov) check("fields", dut_word(), m_word);
        check("illegal", illegal, CHK_EN ? m_ill : 1'b0);
        check("sticky_err", sticky_err, CHK_EN ? m_sticky : 1'b0);
        if (ctl_valid && rdy && !r) got.push_back(dut_word());
        @(posedge clk);
        if (r) begin
            m_fq.delete();
            m_ov = 1'b0; m_word = '0; m_ill = 1'b0; m_sticky = 1'b0;
        end else begin
            pop = (m_fq.size() > 0) && (!m_ov || rdy);
            psh = vld && (m_fq.size() < DEPTH);
            if (m_ov && rdy && !pop) begin
                m_ov = 1'b0; m_ill = 1'b0;
            end
            if (pop) begin
                m_word = m_fq.pop_front();
                m_ov = 1'b1;
                m_ill = is_ill(m_word);
                m_sticky = m_sticky | m_ill;
            end
            if (psh) m_fq.push_back(w);
        end
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_ov || m_fq.size() > 0) && n < 30) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            n++;
        end
        check("drain_bound", (m_ov || m_fq.size() > 0), 0);
    endtask

    logic [OP_W-1:0] wl[6];

    initial begin
        vecs[0] = '{8'b1011_1101, 1'b1, 1'b0, 1'b1, 2'b11, 3'b101};
        vecs[1] = '{8'b0100_0000, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000};
        vecs[2] = '{8'b1100_1010, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010};
        vecs[3] = '{8'b0001_0111, 1'b0, 1'b0, 1'b0, 2'b10, 3'b111};
        vecs[4] = '{8'b1110_0110, 1'b1, 1'b1, 1'b1, 2'b00, 3'b110};
        wl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        m_ov = 1'b0; m_word = '0; m_ill = 1'b0; m_sticky = 1'b0;
        rst = 1'b1; op_valid = 1'b0; ALUop = '0; ctl_ready = 1'b0;
        @(posedge clk); #1;
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("reset_count", count, 0);
        check("reset_valid", ctl_valid, 0);
        check("reset_ready", op_ready, 1);
        check("reset_fields", dut_word(), 0);

        // Decode table; each word enters an empty block.
        foreach (vecs[i]) begin
            cyc(1'b1, vecs[i].word, 1'b1, 1'b0);
            check("lat_not_yet", ctl_valid, 0);
            cyc(1'b0, '0, 1'b1, 1'b0);
            check("tbl_valid", ctl_valid, 1);
            check("tbl_arith", isArith, vecs[i].arith);
            check("tbl_twoc", isTwoC, vecs[i].twoc);
            check("tbl_lr", LeftOrRight, vecs[i].lr);
            check("tbl_op", Operation, vecs[i].op);
            check("tbl_flag", SetFlag, vecs[i].flag);
            drain();
        end

        // Fill with consumer stalled: five accepted, sixth held.
        cyc(1'b0, '0, 1'b0, 1'b1);
        got.delete();
        for (int i = 0; i < 6; i++) cyc(1'b1, wl[i], 1'b0, 1'b0);
        check("full_count", count, 4);
        check("full_ready", op_ready, 0);
        check("full_valid", ctl_valid, 1);
        check("full_head", dut_word(), wl[0]);
        drain();
        check("order_n", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check("order_word", got[i], wl[i]);

        // Sustained traffic from a full queue.
        cyc(1'b0, '0, 1'b0, 1'b1);
        got.delete();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
            check("stream_valid", ctl_valid, 1);
            check("stream_cnt_hi", (count >= DEPTH - 1), 1);
        end
        check("stream_words", got.size(), 10);
        for (int i = 0; i < 5 && i < got.size(); i++) check("stream_order", got[i], 8'h80 + 8'(i));
        drain();

        // Reset during traffic discards everything.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        check("pre_rst_count", count, 3);
        check("pre_rst_valid", ctl_valid, 1);
        cyc(1'b1, 8'hEE, 1'b1, 1'b1);
        check("rst_count", count, 0);
        check("rst_valid", ctl_valid, 0);
        check("rst_ready", op_ready, 1);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("post_rst_valid", ctl_valid, 1);
        check("post_rst_word", dut_word(), 8'hC3);
        drain();

        // Illegal then legal opcode.
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 8'b0100_0000, 1'b1, 1'b0);
        cyc(1'b1, 8'b1000_0000, 1'b1, 1'b0);
        check("ill_first", illegal, CHK_EN);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("ill_second", illegal, 0);
        check("sticky_set", sticky_err, CHK_EN);
        drain();
        check("sticky_hold", sticky_err, CHK_EN);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("sticky_clr", sticky_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
